screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter COLOR_W, default 12: pixel colour width in bits.
REQ-002 SHALL have parameter NUM_PLAYERS, default 2, legal range 2..8: number of win screens.
REQ-003 SHALL have parameter HOLD_FRAMES, default 180, legal range 1..65535: frames the win screen is held.
REQ-004 SHALL have parameter BLINK_FRAMES, default 15, legal range 1..255: blink half-period in frames (used only with SCREEN_BLINK_EN).
REQ-005 SHALL have ports: clk input 1, single clock, all logic on the rising edge.
REQ-006 SHALL have port reset input 1: asynchronous, active-low.
REQ-007 SHALL have port frame_tick input 1: one-cycle pulse per video frame.
REQ-008 SHALL have port start input 1: level play-enable switch.
REQ-009 SHALL have port winner_valid input 1: one-cycle pulse, game over.
REQ-010 SHALL have port winner_id input W, where W = max(1, ceil(log2(NUM_PLAYERS))): index of the winning player, qualified by winner_valid.
REQ-011 SHALL have port game_pix input COLOR_W: in-game pixel.
REQ-012 SHALL have port title_pix input COLOR_W: title-screen pixel.
REQ-013 SHALL have port win_pix input NUM_PLAYERS*COLOR_W: win screens packed, player p at bits [p*COLOR_W +: COLOR_W].
REQ-014 SHALL have port pix_out output COLOR_W: registered selected pixel.
REQ-015 SHALL have port state_out output 2: 00 TITLE, 01 PLAY, 10 WIN; 11 unused.
REQ-016 SHALL have port reset_screen output 1: one-cycle pulse requesting a game-logic reset.

Function
REQ-017 SHALL implement an FSM with states TITLE, PLAY and WIN.
REQ-018 TITLE->PLAY SHALL occur only on a cycle with frame_tick=1 and start=1.
REQ-019 PLAY->WIN SHALL occur on winner_valid=1 with winner_id<NUM_PLAYERS; winner_id SHALL be latched on that cycle.
REQ-020 In PLAY, winner_valid with winner_id>=NUM_PLAYERS SHALL be ignored.
REQ-021 PLAY->TITLE SHALL occur when start=0 and no valid winner_valid on that cycle; winner_valid takes priority if both occur.
REQ-022 On WIN entry, the frame counter SHALL clear to 0 and increment on each frame_tick.
REQ-023 When the counter reaches HOLD_FRAMES (on a frame_tick), the FSM SHALL go WIN->TITLE and reset_screen SHALL pulse high for exactly that transition cycle.
REQ-024 start SHALL be ignored in WIN.
REQ-025 winner_valid SHALL be ignored in TITLE and WIN.
REQ-026 pix_out SHALL be registered with 1-cycle latency from its selected input: title_pix in TITLE, game_pix in PLAY, win slice of the latched winner in WIN.
REQ-027 Selection SHALL use the state after the current edge's update, so the first pixel of a new state appears one cycle after the transition edge.
REQ-028 state_out SHALL be the registered state with no added latency.
REQ-029 The frame counter SHALL saturate and never wrap; width is ceil(log2(HOLD_FRAMES+1)) bits.
REQ-030 reset_screen SHALL be 0 on every cycle other than the WIN->TITLE transition.

Reset
REQ-031 On reset=0, asynchronously: state=TITLE, pix_out=0, reset_screen=0, frame counter=0, latched winner=0, blink phase=0.
REQ-032 After reset deasserts, the first FSM transition SHALL need a fresh qualifying frame_tick; a reset mid-WIN SHALL NOT emit reset_screen.

Configuration
REQ-033 Macro SCREEN_BLINK_EN, when defined, SHALL enable blinking in WIN.
REQ-034 With SCREEN_BLINK_EN, a blink counter SHALL count frame_ticks and toggle the phase every BLINK_FRAMES frames; in phase 1, pix_out=0.
REQ-035 With SCREEN_BLINK_EN, the phase SHALL clear to 0 on WIN entry.
REQ-036 Without SCREEN_BLINK_EN, the win screen SHALL be shown steadily and no blink logic SHALL be synthesised.

Verification
REQ-037 Reset then start=1 with no frame_tick for 10 cycles -> state_out=00, pix_out=title_pix; on a frame_tick -> state_out=01 next edge, pix_out=game_pix one cycle later.
REQ-038 In PLAY, NUM_PLAYERS=2, winner_valid with winner_id=1 -> state_out=10, pix_out=win_pix[23:12]; winner_id=3 with NUM_PLAYERS=3 -> ignored, remains PLAY.
REQ-039 HOLD_FRAMES=3, in WIN issue 3 frame_ticks -> exactly one reset_screen pulse coincident with state_out 10->00; no pulse otherwise.
REQ-040 In PLAY, same cycle start=0 and valid winner_valid -> WIN entered, not TITLE.
REQ-041 Assert reset=0 asynchronously mid-WIN between clock edges -> pix_out=0 and state_out=00 immediately, reset_screen stays 0.
REQ-042 With SCREEN_BLINK_EN, BLINK_FRAMES=2 -> in WIN, pix_out alternates win slice / 0 every 2 frame_ticks, starting with the win slice.

Source files
------------

// File: rtl/screen_sequencer.sv
// Title / play / win screen sequencer with a registered pixel mux and a game-reset pulse on leaving WIN.
// Optional build macro SCREEN_BLINK_EN blinks the win screen with half-period BLINK_FRAMES.
module screen_sequencer #(
  parameter int COLOR_W      = 12,
  parameter int NUM_PLAYERS  = 2,
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_FRAMES = 15,
  localparam int ID_W  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           start,
  input  logic                           winner_valid,
  input  logic [ID_W-1:0]                winner_id,
  input  logic [COLOR_W-1:0]             game_pix,
  input  logic [COLOR_W-1:0]             title_pix,
  input  logic [NUM_PLAYERS*COLOR_W-1:0] win_pix,
  output logic [COLOR_W-1:0]             pix_out,
  output logic [1:0]                     state_out,
  output logic                           reset_screen
);

  typedef enum logic [1:0] {
    TITLE = 2'b00,
    PLAY  = 2'b01,
    WIN   = 2'b10
  } state_t;

  localparam logic [ID_W:0]    NUM_ID    = (ID_W + 1)'(NUM_PLAYERS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_FRAMES);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || HOLD_FRAMES < 1 || HOLD_FRAMES > 65535 ||
      BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_params
    $error("screen_sequencer: parameter out of legal range");
  end

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic [ID_W-1:0]    winner_r, winner_next_s;
  logic [COLOR_W-1:0] pix_r, pix_next_s;
  logic               reset_screen_r, exit_win_s, win_ok_s, win_entry_s;
  logic [COLOR_W-1:0] win_arr_s [NUM_PLAYERS];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_win_slice
    assign win_arr_s[p] = win_pix[p*COLOR_W +: COLOR_W];
  end

  assign win_ok_s    = winner_valid && ({1'b0, winner_id} < NUM_ID);
  assign win_entry_s = (state_r == PLAY) && win_ok_s;

  // Next-state logic; the winner report outranks start dropping in PLAY.
  always_comb begin
    state_next_s = state_r;
    exit_win_s   = 1'b0;
    case (state_r)
      TITLE: begin
        if (frame_tick && start) state_next_s = PLAY;
        else                     state_next_s = TITLE;
      end
      PLAY: begin
        if (win_ok_s)    state_next_s = WIN;
        else if (!start) state_next_s = TITLE;
        else             state_next_s = PLAY;
      end
      WIN: begin
        if (frame_tick && (cnt_r >= HOLD_LAST)) begin
          state_next_s = TITLE;
          exit_win_s   = 1'b1;
        end else begin
          state_next_s = WIN;
        end
      end
      default: state_next_s = TITLE;
    endcase
  end

  // Hold-frame counter (saturating) and winner latch.
  always_comb begin
    cnt_next_s    = cnt_r;
    winner_next_s = winner_r;
    if (win_entry_s) begin
      cnt_next_s    = {CNT_W{1'b0}};
      winner_next_s = winner_id;
    end else if ((state_r == WIN) && frame_tick && (cnt_r != HOLD_MAX)) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

`ifdef SCREEN_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  logic [7:0] blink_cnt_r, blink_cnt_next_s;
  logic       blink_phase_r, blink_phase_next_s;

  // Blink phase toggles every BLINK_FRAMES ticks while in WIN; restarts visible on entry.
  always_comb begin
    blink_cnt_next_s   = blink_cnt_r;
    blink_phase_next_s = blink_phase_r;
    if (win_entry_s) begin
      blink_cnt_next_s   = 8'd0;
      blink_phase_next_s = 1'b0;
    end else if ((state_r == WIN) && frame_tick) begin
      if (blink_cnt_r >= BLINK_LAST) begin
        blink_cnt_next_s   = 8'd0;
        blink_phase_next_s = ~blink_phase_r;
      end else begin
        blink_cnt_next_s = blink_cnt_r + 8'd1;
      end
    end else begin
      blink_cnt_next_s = blink_cnt_r;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_r   <= 8'd0;
      blink_phase_r <= 1'b0;
    end else begin
      blink_cnt_r   <= blink_cnt_next_s;
      blink_phase_r <= blink_phase_next_s;
    end
  end
`else
  logic blink_phase_r;
  assign blink_phase_r = 1'b0;
`endif

  // Pixel source follows the registered state, so a new screen lags its state by one cycle.
  always_comb begin
    pix_next_s = {COLOR_W{1'b0}};
    case (state_r)
      TITLE:   pix_next_s = title_pix;
      PLAY:    pix_next_s = game_pix;
      WIN: begin
        if (blink_phase_r) pix_next_s = {COLOR_W{1'b0}};
        else               pix_next_s = win_arr_s[winner_r];
      end
      default: pix_next_s = {COLOR_W{1'b0}};
    endcase
  end

  // Main state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= TITLE;
      cnt_r          <= {CNT_W{1'b0}};
      winner_r       <= {ID_W{1'b0}};
      pix_r          <= {COLOR_W{1'b0}};
      reset_screen_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      cnt_r          <= cnt_next_s;
      winner_r       <= winner_next_s;
      pix_r          <= pix_next_s;
      reset_screen_r <= exit_win_s;
    end
  end

  assign pix_out      = pix_r;
  assign state_out    = state_r;
  assign reset_screen = reset_screen_r;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed table-driven bench for screen_sequencer (3 players, 3 hold frames, blink half-period 2).
module tb_screen_sequencer;

  localparam int CW = 12;
  localparam int NP = 3;
`ifdef SCREEN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           frame_tick = 1'b0, start = 1'b0, winner_valid = 1'b0;
  logic [1:0]     winner_id = 2'd0;
  logic [CW-1:0]  game_pix  = 12'h222;
  logic [CW-1:0]  title_pix = 12'h111;
  logic [NP*CW-1:0] win_pix = {12'hC03, 12'hB02, 12'hA01};
  logic [CW-1:0]  pix_out;
  logic [1:0]     state_out;
  logic           reset_screen;

  int checks = 0;
  int errors = 0;

  screen_sequencer #(.COLOR_W(CW), .NUM_PLAYERS(NP), .HOLD_FRAMES(3), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .winner_valid(winner_valid), .winner_id(winner_id), .game_pix(game_pix),
    .title_pix(title_pix), .win_pix(win_pix), .pix_out(pix_out),
    .state_out(state_out), .reset_screen(reset_screen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ft;
    logic        st;
    logic        wv;
    logic [1:0]  wid;
    logic [1:0]  est;
    logic [11:0] epix;
    logic        ers;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ft, input logic st, input logic wv, input logic [1:0] wid);
    frame_tick = ft; start = st; winner_valid = wv; winner_id = wid;
  endtask

  initial begin
    // ft st wv wid | state pix rs  (pix reflects the state before each edge)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 12'h111, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'd1, 2'b00, 12'h111, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b01, 12'h111, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b01, 12'h222, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 2'b01, 12'h222, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd1, 2'b10, 12'h222, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'b10, 12'hB02, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 2'b10, 12'hB02, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 12'hB02, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b10, BLINK ? 12'h000 : 12'hB02, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b00, BLINK ? 12'h000 : 12'hB02, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b00, 12'h111, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b01, 12'h111, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'b10, 12'h222, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'b10, 12'hC03, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'b10, 12'hC03, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'b10, 12'hC03, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'b00, BLINK ? 12'h000 : 12'hC03, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 12'h111, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b01, 12'h111, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 2'd3, 2'b00, 12'h222, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 12'h111, 1'b0};

    #1;
    chk("rst_state", {30'd0, state_out}, 32'd0);
    chk("rst_pix", {20'd0, pix_out}, 32'd0);
    chk("rst_rs", {31'd0, reset_screen}, 32'd0);
    #21 reset = 1'b1;

    // start held with no frame_tick: stay on the title screen
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_state", {30'd0, state_out}, 32'd0);
      chk("idle_pix", {20'd0, pix_out}, 32'h111);
    end

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].ft, vecs[i].st, vecs[i].wv, vecs[i].wid);
      step();
      chk($sformatf("vec%0d_state", i), {30'd0, state_out}, {30'd0, vecs[i].est});
      chk($sformatf("vec%0d_pix", i), {20'd0, pix_out}, {20'd0, vecs[i].epix});
      chk($sformatf("vec%0d_rs", i), {31'd0, reset_screen}, {31'd0, vecs[i].ers});
    end

    // Enter WIN with player 0, then pull reset between edges
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("pre_play", {30'd0, state_out}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 2'd0);
    step();
    chk("pre_win", {30'd0, state_out}, 32'd2);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("win_pix0", {20'd0, pix_out}, 32'hA01);
    #2 reset = 1'b0;
    #1;
    chk("async_state", {30'd0, state_out}, 32'd0);
    chk("async_pix", {20'd0, pix_out}, 32'd0);
    chk("async_rs", {31'd0, reset_screen}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("inrst_rs", {31'd0, reset_screen}, 32'd0);
      chk("inrst_state", {30'd0, state_out}, 32'd0);
    end
    #3 reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_hold", {30'd0, state_out}, 32'd0);
      chk("post_rst_rs", {31'd0, reset_screen}, 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("post_rst_play", {30'd0, state_out}, 32'd1);
    chk("post_rst_pix", {20'd0, pix_out}, 32'h111);
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    step();
    chk("post_rst_game", {20'd0, pix_out}, 32'h222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
